// File: rtl/key_cmd_queue.sv
// key_cmd_queue: decodes HID key-press events into game commands and buffers them in a circular FIFO
module key_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [7:0]               key,
   input  logic                     cmd_ready,
   input  logic                     ovf_clr,
   output logic                     cmd_valid,
   output logic [2:0]               cmd,
   output logic [7:0]               cmd_key,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [10:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [2:0]    dec;
   logic          push, pop, wr_en, drop;
   always_comb begin
      dec = key == 8'h1A ? 3'd1 :
            key == 8'h04 ? 3'd2 :
            key == 8'h16 ? 3'd3 :
            key == 8'h07 ? 3'd4 :
            key == 8'h2C ? 3'd5 :
            key == 8'h28 ? 3'd6 : 3'd0;
      push = dec != 3'd0;
      pop = cmd_valid && cmd_ready;
      // a pop frees the slot in the same cycle, so a full queue still accepts
      wr_en = push && (count != FULL || pop);
      drop = push && count == FULL && !pop;
   end
   assign cmd_valid = count != '0;
   assign cmd = cmd_valid ? mem[rd_ptr][10:8] : 3'd0;
   assign cmd_key = cmd_valid ? mem[rd_ptr][7:0] : 8'd0;
   always_ff @(posedge Clk) begin
      if (Reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count <= '0;
         overflow <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= {dec, key};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
         overflow <= drop ? 1'b1 : ovf_clr ? 1'b0 : overflow;
      end
   end
endmodule

// File: tb/tb_key_cmd_queue.sv
// tb_key_cmd_queue: directed and random stimulus against a queue-based reference model
module tb_key_cmd_queue;
   localparam int DEPTH = 4;
   logic       Clk = 1'b0, Reset = 1'b1, cmd_ready = 1'b0, ovf_clr = 1'b0;
   logic [7:0] key = 8'h00;
   logic       cmd_valid, overflow;
   logic [2:0] cmd;
   logic [7:0] cmd_key;
   logic [$clog2(DEPTH):0] count;
   int errors = 0, checks = 0;
   logic [10:0] q[$];
   logic        ovf = 1'b0;
   logic [7:0]  keys [6] = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C, 8'h28};

   key_cmd_queue #(.DEPTH(DEPTH)) dut (
      .Clk(Clk), .Reset(Reset), .key(key), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_key(cmd_key), .count(count), .overflow(overflow)
   );

   always #5 Clk = ~Clk;

   function automatic logic [2:0] decode(input logic [7:0] k);
      for (int i = 0; i < 6; i++) if (keys[i] == k) return 3'(i + 1);
      return 3'd0;
   endfunction

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      logic v;
      v = q.size() != 0;
      chk("count", int'(count), q.size());
      chk("cmd_valid", int'(cmd_valid), int'(v));
      chk("cmd", int'(cmd), v ? int'(q[0][10:8]) : 0);
      chk("cmd_key", int'(cmd_key), v ? int'(q[0][7:0]) : 0);
      chk("overflow", int'(overflow), int'(ovf));
   endtask

   task automatic step(input logic [7:0] k, input logic rdy, input logic clr, input logic rst);
      int sz;
      logic p, d;
      key = k; cmd_ready = rdy; ovf_clr = clr; Reset = rst;
      @(posedge Clk);
      if (rst) begin
         q.delete();
         ovf = 1'b0;
      end else begin
         sz = q.size();
         p = sz > 0 && rdy;
         d = 1'b0;
         if (p) void'(q.pop_front());
         if (decode(k) != 3'd0) begin
            if (sz == DEPTH && !p) d = 1'b1;
            else q.push_back({decode(k), k});
         end
         ovf = d ? 1'b1 : clr ? 1'b0 : ovf;
      end
      #1;
      check_all();
   endtask

   initial begin
      int r;
      logic [7:0] k;
      step(8'h00, 1'b0, 1'b0, 1'b1);
      step(8'h1A, 1'b1, 1'b1, 1'b1);
      step(8'h1A, 1'b0, 1'b0, 1'b0);
      chk("basic_cmd", int'(cmd), 1);
      chk("basic_key", int'(cmd_key), 8'h1A);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("basic_empty", int'(count), 0);
      step(8'h05, 1'b0, 1'b0, 1'b0);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      foreach (keys[i]) step(keys[i == 0 ? 1 : i], 1'b0, 1'b0, 1'b0);
      chk("fill_ovf", int'(overflow), 1);
      repeat (5) step(8'h00, 1'b1, 1'b0, 1'b0);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i < 5; i++) step(keys[i], 1'b0, 1'b0, 1'b0);
      step(8'h28, 1'b1, 1'b0, 1'b0);
      chk("full_pushpop_cnt", int'(count), 4);
      chk("full_pushpop_ovf", int'(overflow), 0);
      repeat (3) step(8'h00, 1'b1, 1'b0, 1'b0);
      chk("start_last", int'(cmd), 6);
      step(8'h00, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i < 5; i++) step(keys[i], 1'b0, 1'b0, 1'b0);
      step(8'h28, 1'b0, 1'b1, 1'b0);
      chk("clr_vs_set", int'(overflow), 1);
      step(8'h00, 1'b0, 1'b1, 1'b0);
      chk("clr_alone", int'(overflow), 0);
      step(8'h1A, 1'b0, 1'b0, 1'b0);
      step(8'h2C, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) step(keys[i], 1'b0, 1'b0, 1'b0);
      step(8'h16, 1'b0, 1'b0, 1'b1);
      chk("rst_mid_valid", int'(cmd_valid), 0);
      step(8'h07, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_cmd", int'(cmd), 4);
      for (int n = 0; n < 600; n++) begin
         r = int'($urandom_range(0, 9));
         k = r < 6 ? keys[r] : r == 6 ? 8'(($urandom_range(1, 255))) : 8'h00;
         step(k, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
